// File: rtl/posit_pkg.sv
// Shared definitions for the SIMD posit encoder: lane modes, widths, exponent sizes,
// the per-beat stage-1 record and the lane rounding/packing helper.
package posit_pkg;

  typedef enum logic [1:0] {
    MODE_P8  = 2'b00,
    MODE_P16 = 2'b01,
    MODE_P32 = 2'b10
  } mode_e;

  localparam int N_P8  = 8;
  localparam int N_P16 = 16;
  localparam int N_P32 = 32;

  localparam int ES_P8  = 0;
  localparam int ES_P16 = 1;
  localparam int ES_P32 = 2;

  // Largest representable |scale| for an n-bit posit with es exponent bits.
  function automatic int max_scale(input int n, input int es);
    return (n - 2) << es;
  endfunction

  localparam int MAXSCALE_P8  = max_scale(N_P8,  ES_P8);
  localparam int MAXSCALE_P16 = max_scale(N_P16, ES_P16);
  localparam int MAXSCALE_P32 = max_scale(N_P32, ES_P32);

  function automatic logic [31:0] nar_pat(input int n);
    return 32'd1 << (n - 1);
  endfunction

  function automatic logic [31:0] maxpos_pat(input int n);
    return (32'd1 << (n - 1)) - 32'd1;
  endfunction

  localparam logic [31:0] MINPOS_PAT = 32'd1;

  // Lane slots follow the sign mapping: P8 lane i -> slot i, P16 lane j -> slot 2j+1,
  // P32 -> slot 3. Magnitudes sit at the LSBs of their lane's bit field.
  typedef struct packed {
    mode_e       mode;
    logic [30:0] mag;
    logic [3:0]  guard;
    logic [3:0]  rsticky;
    logic [3:0]  sat_hi;
    logic [3:0]  sat_lo;
    logic [3:0]  sign;
    logic [3:0]  zero;
    logic [3:0]  nar;
  } stage1_t;

  // Round-to-nearest-even, saturate, apply sign and special values for one n-bit lane.
  function automatic logic [31:0] round_lane(
    input int          n,
    input logic [31:0] mag,
    input logic        guard,
    input logic        rsticky,
    input logic        sat_hi,
    input logic        sat_lo,
    input logic        sign,
    input logic        zero,
    input logic        nar
  );
    logic [31:0] mag_mask;
    logic [31:0] m;
    logic [31:0] word;
    mag_mask = maxpos_pat(n);
    if (sat_hi)
      m = mag_mask;
    else if (sat_lo)
      m = MINPOS_PAT;
    else if (guard && (rsticky || mag[0]))
      m = (mag == mag_mask) ? mag_mask : mag + 32'd1;  // carry would land on NaR
    else
      m = mag;
    word = m & mag_mask;
    if (sign)
      word = (~word + 32'd1) & (mag_mask | nar_pat(n));
    if (nar)
      word = nar_pat(n);
    else if (zero)
      word = '0;
    return word;
  endfunction

endpackage

// File: rtl/posit_lane_enc.sv
// Stage-1 lane assembly: lays out {regime, exponent, fraction} for one posit lane and
// splits it into the unrounded magnitude, guard bit and sticky bit. Purely combinational.
module posit_lane_enc #(
  parameter int N  = 8,
  parameter int ES = 0,
  parameter int SW = 4,
  parameter int FW = 7
) (
  input  logic [SW-1:0] scale,
  input  logic [FW-1:0] frac,
  input  logic          sticky,
  output logic [N-2:0]  mag,
  output logic          guard,
  output logic          rsticky
);

  localparam int TW = 1 + ES + FW;
  localparam int BW = TW + N;

  logic [SW-1:0] k;
  logic          fill;
  logic [SW:0]   k_ext;
  logic [SW:0]   run_full;
  logic [SW:0]   run;
  logic [TW-1:0] tail;
  logic [BW-1:0] base;
  logic [BW-1:0] shifted;

  assign k     = SW'($signed(scale) >>> ES);
  assign fill  = ~k[SW-1];
  assign k_ext = {k[SW-1], k};

  // Regime run length: k+1 ones for k>=0, -k zeros otherwise. Runs past the lane are
  // clamped; such scales are saturated downstream anyway.
  assign run_full = fill ? k_ext + (SW+1)'(1) : ~k_ext + (SW+1)'(1);
  assign run      = (run_full > (SW+1)'(N)) ? (SW+1)'(N) : run_full;

  if (ES > 0) begin : g_exp
    assign tail = {~fill, scale[ES-1:0], frac};
  end else begin : g_noexp
    assign tail = {~fill, frac};
  end

  // The N zero bits below the tail absorb the shift, so nothing is lost before the sticky OR.
  assign base    = {tail, {N{1'b0}}};
  assign shifted = (base >> run) | (fill ? ~({BW{1'b1}} >> run) : '0);

  assign mag     = shifted[BW-1 -: N-1];
  assign guard   = shifted[BW-N];
  assign rsticky = sticky | (|shifted[BW-N-1:0]);

endmodule

// File: rtl/posit_pack.sv
// SIMD posit encoder: two-stage valid/ready pipeline packing 4xP8, 2xP16 or 1xP32
// lanes from sign/scale/fraction with round-to-nearest-even.
module posit_pack
  import posit_pkg::*;
#(
  parameter int W    = 32,
  parameter int ES8  = ES_P8,
  parameter int ES16 = ES_P16,
  parameter int ES32 = ES_P32
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic           in_valid,
  output logic           in_ready,
  input  logic [1:0]     mode,
  input  logic [W/8-1:0] s,
  input  logic [W/2-1:0] scale,
  input  logic [W-5:0]   frac,
  input  logic [W/8-1:0] sticky,
  input  logic [W/8-1:0] zero,
  input  logic [W/8-1:0] nar,
  output logic           out_valid,
  input  logic           out_ready,
  output logic [W-1:0]   out
);

  localparam int MAXSC8  = max_scale(N_P8,  ES8);
  localparam int MAXSC16 = max_scale(N_P16, ES16);
  localparam int MAXSC32 = max_scale(N_P32, ES32);

  logic [6:0]  p8_mag  [4];
  logic [3:0]  p8_g, p8_s, p8_hi, p8_lo;
  logic [14:0] p16_mag [2];
  logic [1:0]  p16_g, p16_s, p16_hi, p16_lo;
  logic [30:0] p32_mag;
  logic        p32_g, p32_s, p32_hi, p32_lo;

  for (genvar i = 0; i < 4; i++) begin : g_p8
    posit_lane_enc #(.N(N_P8), .ES(ES8), .SW(4), .FW(7)) u_enc (
      .scale   (scale[4*i +: 4]),
      .frac    (frac[7*i +: 7]),
      .sticky  (sticky[i]),
      .mag     (p8_mag[i]),
      .guard   (p8_g[i]),
      .rsticky (p8_s[i])
    );
    assign p8_hi[i] = int'($signed(scale[4*i +: 4])) >  MAXSC8;
    assign p8_lo[i] = int'($signed(scale[4*i +: 4])) < -MAXSC8;
  end

  for (genvar j = 0; j < 2; j++) begin : g_p16
    posit_lane_enc #(.N(N_P16), .ES(ES16), .SW(8), .FW(14)) u_enc (
      .scale   (scale[8*j +: 8]),
      .frac    (frac[14*j +: 14]),
      .sticky  (sticky[2*j+1]),
      .mag     (p16_mag[j]),
      .guard   (p16_g[j]),
      .rsticky (p16_s[j])
    );
    assign p16_hi[j] = int'($signed(scale[8*j +: 8])) >  MAXSC16;
    assign p16_lo[j] = int'($signed(scale[8*j +: 8])) < -MAXSC16;
  end

  posit_lane_enc #(.N(N_P32), .ES(ES32), .SW(16), .FW(28)) u_enc_p32 (
    .scale   (scale),
    .frac    (frac),
    .sticky  (sticky[3]),
    .mag     (p32_mag),
    .guard   (p32_g),
    .rsticky (p32_s)
  );
  assign p32_hi = int'($signed(scale)) >  MAXSC32;
  assign p32_lo = int'($signed(scale)) < -MAXSC32;

  // Stage 1 record: the selected mode's lanes placed in a shared slot layout.
  stage1_t st1_d, st1_q;

  always_comb begin
    st1_d      = '0;
    st1_d.sign = s;
    st1_d.zero = zero;
    st1_d.nar  = nar;
    case (mode)
      2'b00: begin
        st1_d.mode = MODE_P8;
        for (int i = 0; i < 4; i++) begin
          st1_d.mag[8*i +: 7] = p8_mag[i];
        end
        st1_d.guard   = p8_g;
        st1_d.rsticky = p8_s;
        st1_d.sat_hi  = p8_hi;
        st1_d.sat_lo  = p8_lo;
      end
      2'b01: begin
        st1_d.mode = MODE_P16;
        for (int j = 0; j < 2; j++) begin
          st1_d.mag[16*j +: 15]  = p16_mag[j];
          st1_d.guard[2*j+1]     = p16_g[j];
          st1_d.rsticky[2*j+1]   = p16_s[j];
          st1_d.sat_hi[2*j+1]    = p16_hi[j];
          st1_d.sat_lo[2*j+1]    = p16_lo[j];
        end
      end
      default: begin
        st1_d.mode       = MODE_P32;
        st1_d.mag        = p32_mag;
        st1_d.guard[3]   = p32_g;
        st1_d.rsticky[3] = p32_s;
        st1_d.sat_hi[3]  = p32_hi;
        st1_d.sat_lo[3]  = p32_lo;
      end
    endcase
  end

  // Stage 2: round and pack every lane shape, then pick by the registered mode.
  logic [31:0] w8  [4];
  logic [31:0] w16 [2];
  logic [31:0] w32;
  logic [31:0] out_d;

  for (genvar i = 0; i < 4; i++) begin : g_r8
    assign w8[i] = round_lane(N_P8, {25'b0, st1_q.mag[8*i +: 7]}, st1_q.guard[i],
                              st1_q.rsticky[i], st1_q.sat_hi[i], st1_q.sat_lo[i],
                              st1_q.sign[i], st1_q.zero[i], st1_q.nar[i]);
  end

  for (genvar j = 0; j < 2; j++) begin : g_r16
    assign w16[j] = round_lane(N_P16, {17'b0, st1_q.mag[16*j +: 15]}, st1_q.guard[2*j+1],
                               st1_q.rsticky[2*j+1], st1_q.sat_hi[2*j+1], st1_q.sat_lo[2*j+1],
                               st1_q.sign[2*j+1], st1_q.zero[2*j+1], st1_q.nar[2*j+1]);
  end

  assign w32 = round_lane(N_P32, {1'b0, st1_q.mag}, st1_q.guard[3], st1_q.rsticky[3],
                          st1_q.sat_hi[3], st1_q.sat_lo[3], st1_q.sign[3],
                          st1_q.zero[3], st1_q.nar[3]);

  always_comb begin
    out_d = '0;
    case (st1_q.mode)
      MODE_P8: begin
        for (int i = 0; i < 4; i++) begin
          out_d[8*i +: 8] = w8[i][7:0];
        end
      end
      MODE_P16: begin
        for (int j = 0; j < 2; j++) begin
          out_d[16*j +: 16] = w16[j][15:0];
        end
      end
      default: out_d = w32;
    endcase
  end

  // Pipeline control
  logic v1, v2;
  logic adv2;

  assign adv2      = !v2 || out_ready;
  assign in_ready  = !v1 || adv2;
  assign out_valid = v2;

  // NOTE: state updates use non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      v1  <= 1'b0;
      v2  <= 1'b0;
      out <= '0;
    end else begin
      if (adv2) begin
        v2 <= v1;
        if (v1) out <= out_d;
      end
      if (in_ready) v1 <= in_valid;
    end
  end

  // NOTE: payload register carries no reset; v1 qualifies it, so stale contents are never used.
  always_ff @(posedge clk) begin
    if (in_ready && in_valid) st1_q <= st1_d;
  end

endmodule

// File: tb/tb_posit_pack.sv
// Directed-vector bench for posit_pack: latency, lane packing, rounding, saturation,
// special values, backpressure and mid-flight reset.
module tb_posit_pack;

  logic        clk;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [1:0]  mode;
  logic [3:0]  s;
  logic [15:0] scale;
  logic [27:0] frac;
  logic [3:0]  sticky;
  logic [3:0]  zero;
  logic [3:0]  nar;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out;

  int n_checks;
  int n_pass;

  posit_pack dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .mode      (mode),
    .s         (s),
    .scale     (scale),
    .frac      (frac),
    .sticky    (sticky),
    .zero      (zero),
    .nar       (nar),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out       (out)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %08h expected %08h", tag, got, exp);
  endtask

  task automatic step;
    @(posedge clk);
    #1;
  endtask

  task automatic apply(input logic [1:0] m, input logic [3:0] sg, input logic [15:0] sc,
                       input logic [27:0] fr, input logic [3:0] st, input logic [3:0] zr,
                       input logic [3:0] nr);
    mode     = m;
    s        = sg;
    scale    = sc;
    frac     = fr;
    sticky   = st;
    zero     = zr;
    nar      = nr;
    in_valid = 1'b1;
  endtask

  task automatic send(input string tag);
    int n;
    n = 0;
    while (!in_ready && n < 20) begin
      step;
      n++;
    end
    if (!in_ready) check({tag, "_accept"}, {31'b0, in_ready}, 32'd1);
    step;
    in_valid = 1'b0;
  endtask

  task automatic expect_out(input string tag, input logic [31:0] exp);
    int n;
    n = 0;
    while (!out_valid && n < 20) begin
      step;
      n++;
    end
    check({tag, "_vld"}, {31'b0, out_valid}, 32'd1);
    check(tag, out, exp);
    step;
  endtask

  initial begin
    n_checks  = 0;
    n_pass    = 0;
    rst_n     = 1'b0;
    in_valid  = 1'b0;
    out_ready = 1'b1;
    mode      = '0;
    s         = '0;
    scale     = '0;
    frac      = '0;
    sticky    = '0;
    zero      = '0;
    nar       = '0;
    repeat (3) step;
    check("rst_out_valid", {31'b0, out_valid}, 32'd0);
    check("rst_out", out, 32'd0);
    check("rst_in_ready", {31'b0, in_ready}, 32'd1);
    rst_n = 1'b1;
    step;

    // P32 unit value and two-cycle latency
    apply(2'b10, 4'b0000, 16'h0000, 28'h0, 4'b0, 4'b0, 4'b0);
    check("t1_rdy", {31'b0, in_ready}, 32'd1);
    step;
    in_valid = 1'b0;
    check("t1_lat1", {31'b0, out_valid}, 32'd0);
    step;
    check("t1_lat2", {31'b0, out_valid}, 32'd1);
    check("t1_out", out, 32'h4000_0000);
    step;
    check("t1_drain", {31'b0, out_valid}, 32'd0);

    // P8 lanes, back to back: basic values, then tie-to-even / round-up / sticky / carry
    apply(2'b00, 4'b0100, 16'h0010, 28'h0, 4'b0, 4'b1000, 4'b0);
    send("t2");
    apply(2'b00, 4'b0000, 16'h0000, {7'b1111111, 7'b0000010, 7'b0000110, 7'b0000010},
          4'b0100, 4'b0, 4'b0);
    send("t3");
    expect_out("t2", 32'h00C0_6040);
    expect_out("t3", 32'h6041_4240);

    // P16 saturation, NaR/zero, and signed values with exponent bits
    apply(2'b01, 4'b0000, 16'hC43C, 28'h0, 4'b0, 4'b0, 4'b0);
    send("t4_sat");
    expect_out("t4_sat", 32'h0001_7FFF);
    apply(2'b01, 4'b1010, 16'h0000, 28'h0, 4'b0, 4'b1000, 4'b0010);
    send("t4_nar");
    expect_out("t4_nar", 32'h0000_8000);
    apply(2'b01, 4'b1000, 16'hFF03, 28'h0, 4'b0, 4'b0, 4'b0);
    send("t4_sgn");
    expect_out("t4_sgn", 32'hD000_6800);

    // P32 boundaries at +/-maxscale (mode 11 behaves as 10) and a negative unit
    apply(2'b11, 4'b0000, 16'hFF88, 28'h0, 4'b0, 4'b0, 4'b0);
    send("p32_minsc");
    expect_out("p32_minsc", 32'h0000_0001);
    apply(2'b11, 4'b0000, 16'h0078, 28'h0, 4'b0, 4'b0, 4'b0);
    send("p32_maxsc");
    expect_out("p32_maxsc", 32'h7FFF_FFFF);
    apply(2'b10, 4'b1000, 16'h0000, 28'h0, 4'b0, 4'b0, 4'b0);
    send("p32_neg");
    expect_out("p32_neg", 32'hC000_0000);

    // Backpressure: three P32 beats offered while out_ready is low for four cycles
    out_ready = 1'b0;
    apply(2'b10, 4'b0, 16'h0000, 28'h0, 4'b0, 4'b0, 4'b0);
    check("t5_rdy_a", {31'b0, in_ready}, 32'd1);
    step;
    apply(2'b10, 4'b0, 16'h0001, 28'h0, 4'b0, 4'b0, 4'b0);
    check("t5_rdy_b", {31'b0, in_ready}, 32'd1);
    step;
    apply(2'b10, 4'b0, 16'hFFFF, 28'h0, 4'b0, 4'b0, 4'b0);
    check("t5_stall0", {31'b0, in_ready}, 32'd0);
    check("t5_vld0", {31'b0, out_valid}, 32'd1);
    check("t5_hold0", out, 32'h4000_0000);
    step;
    check("t5_stall1", {31'b0, in_ready}, 32'd0);
    check("t5_hold1", out, 32'h4000_0000);
    step;
    check("t5_stall2", {31'b0, in_ready}, 32'd0);
    check("t5_hold2", out, 32'h4000_0000);
    out_ready = 1'b1;
    #1;
    check("t5_release", {31'b0, in_ready}, 32'd1);
    step;
    in_valid = 1'b0;
    check("t5_b_vld", {31'b0, out_valid}, 32'd1);
    check("t5_b", out, 32'h4800_0000);
    step;
    check("t5_c_vld", {31'b0, out_valid}, 32'd1);
    check("t5_c", out, 32'h3800_0000);
    step;
    check("t5_empty", {31'b0, out_valid}, 32'd0);

    // Reset with two beats in the pipe
    out_ready = 1'b0;
    apply(2'b10, 4'b0, 16'h0004, 28'h0, 4'b0, 4'b0, 4'b0);
    step;
    apply(2'b10, 4'b0, 16'h0008, 28'h0, 4'b0, 4'b0, 4'b0);
    step;
    in_valid = 1'b0;
    rst_n    = 1'b0;
    step;
    rst_n     = 1'b1;
    out_ready = 1'b1;
    #1;
    check("t6_vld", {31'b0, out_valid}, 32'd0);
    check("t6_out", out, 32'd0);
    check("t6_rdy", {31'b0, in_ready}, 32'd1);
    for (int i = 0; i < 4; i++) begin
      step;
      check("t6_quiet", {31'b0, out_valid}, 32'd0);
    end

    // P8 boundaries after reset: minpos at -maxscale, both saturations, signed minpos
    apply(2'b00, 4'b1000, 16'h87AF, 28'h0, 4'b0, 4'b0, 4'b0);
    send("p8_edge");
    expect_out("p8_edge", 32'hFF7F_0120);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
